// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader: decodes a 4-word header from a 16-bit stream,
// writes the payload through a registered write port and holds the CPU in reset until done.
module instr_mem_loader #(
    parameter int unsigned ADDR_WIDTH = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    input  logic [15:0] inData,
    output logic        inReady,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [15:0] memData,
    output logic        cpuReset,
    output logic [31:0] bootPc,
    output logic        done,
    output logic        err
);
    localparam int unsigned WORD_W = 16;
    localparam int unsigned PTR_W  = 32;

    typedef enum logic [2:0] {
        S_AH   = 3'd0,
        S_AL   = 3'd1,
        S_CH   = 3'd2,
        S_CL   = 3'd3,
        S_DATA = 3'd4,
        S_DONE = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    boot_pc_q, boot_pc_d;
    logic [WORD_W-1:0]   cnt_hi_q, cnt_hi_d;
    logic [PTR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [PTR_W-1:0]    remaining_q, remaining_d;
    logic                mem_write_q, mem_write_d;
    logic [PTR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_data_q, mem_data_d;
    logic                in_ready_q, in_ready_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                hs_c;
    logic                out_of_range_c;
    logic [PTR_W-1:0]    count_c;

    assign hs_c           = inValid && in_ready_q;
    // Any bit set at or above ADDR_WIDTH means the target lies outside the memory.
    assign out_of_range_c = (wr_addr_q >> ADDR_WIDTH) != PTR_W'(0);
    assign count_c        = {cnt_hi_q, inData};

    always_comb begin
        state_d     = state_q;
        boot_pc_d   = boot_pc_q;
        cnt_hi_d    = cnt_hi_q;
        wr_addr_d   = wr_addr_q;
        remaining_d = remaining_q;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        err_d       = err_q;

        case (state_q)
            S_AH: if (hs_c) begin
                boot_pc_d = {inData, boot_pc_q[WORD_W-1:0]};
                state_d   = S_AL;
            end
            S_AL: if (hs_c) begin
                boot_pc_d = {boot_pc_q[PTR_W-1:WORD_W], inData};
                state_d   = S_CH;
            end
            S_CH: if (hs_c) begin
                cnt_hi_d = inData;
                state_d  = S_CL;
            end
            S_CL: if (hs_c) begin
                if (count_c == PTR_W'(0)) begin
                    state_d = S_DONE;
                end else begin
                    wr_addr_d   = boot_pc_q;
                    remaining_d = count_c;
                    state_d     = S_DATA;
                end
            end
            S_DATA: if (hs_c) begin
                mem_data_d = inData;
                mem_addr_d = wr_addr_q;
                // Out-of-range words are consumed but never strobed.
                if (out_of_range_c) begin
                    err_d = 1'b1;
                end else begin
                    mem_write_d = 1'b1;
                end
                wr_addr_d   = wr_addr_q + PTR_W'(1);
                remaining_d = remaining_q - PTR_W'(1);
                if (remaining_q == PTR_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_AH;
        endcase

        in_ready_d  = (state_d != S_DONE);
        cpu_reset_d = (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_AH;
            boot_pc_q   <= '0;
            cnt_hi_q    <= '0;
            wr_addr_q   <= '0;
            remaining_q <= '0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            in_ready_q  <= 1'b1;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_pc_q   <= boot_pc_d;
            cnt_hi_q    <= cnt_hi_d;
            wr_addr_q   <= wr_addr_d;
            remaining_q <= remaining_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            in_ready_q  <= in_ready_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign inReady  = in_ready_q;
    assign memWrite = mem_write_q;
    assign memAddr  = mem_addr_q;
    assign memData  = mem_data_q;
    assign cpuReset = cpu_reset_q;
    assign bootPc   = boot_pc_q;
    assign done     = done_q;
    assign err      = err_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: scoreboard of expected writes checked on every
// strobe, plus per-scenario checks of handshake, release and error behaviour.
module tb_instr_mem_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic [15:0] inData;
    logic        inReady;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [15:0] memData;
    logic        cpuReset;
    logic [31:0] bootPc;
    logic        done;
    logic        err;

    int checks    = 0;
    int errors    = 0;
    int n_strobes = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    instr_mem_loader #(.ADDR_WIDTH(20)) dut (
        .clk      (clk),
        .reset    (reset),
        .inValid  (inValid),
        .inData   (inData),
        .inReady  (inReady),
        .memWrite (memWrite),
        .memAddr  (memAddr),
        .memData  (memData),
        .cpuReset (cpuReset),
        .bootPc   (bootPc),
        .done     (done),
        .err      (err)
    );

    // Memory model: the write is committed on the edge that ends the strobe cycle.
    always @(posedge clk) begin
        if (memWrite === 1'b1) mem[memAddr] = memData;
    end

    // Scoreboard: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (memWrite === 1'b1) begin
            n_strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected addr=%h data=%h required=no strobe", memAddr, memData);
            end else begin
                e = exp_q.pop_front();
                if (memAddr !== e.addr || memData !== e.data) begin
                    errors++;
                    $display("FAIL strobe_payload got addr=%h data=%h required addr=%h data=%h",
                             memAddr, memData, e.addr, e.data);
                end
            end
        end
    end

    function automatic logic [15:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'hxxxx;
    endfunction

    task automatic push_exp(input logic [31:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        inValid = 1'b0;
        inData  = 16'h0000;
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    // Presents one word; the handshake happens on the next rising edge.
    task automatic send_word(input logic [15:0] d);
        inValid = 1'b1;
        inData  = d;
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("FAIL send_ready got=%b required=1", inReady);
        end
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        inValid = 1'b0;
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending got=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (inReady !== 1'b1 || memWrite !== 1'b0 || memAddr !== 32'h0 || memData !== 16'h0 ||
            cpuReset !== 1'b1 || bootPc !== 32'h0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got rdy=%b wr=%b addr=%h data=%h cpurst=%b pc=%h done=%b err=%b required 1 0 0 0 1 0 0 0",
                     inReady, memWrite, memAddr, memData, cpuReset, bootPc, done, err);
        end
    endtask

    task automatic test_basic_load();
        logic [15:0] payload [4];
        payload = '{16'h0000, 16'h0042, 16'h0000, 16'h0046};
        do_reset();
        send_word(16'h0000);
        send_word(16'h0020);
        send_word(16'h0000);
        send_word(16'h0004);
        for (int i = 0; i < 4; i++) begin
            push_exp(32'h20 + 32'(i), payload[i]);
            send_word(payload[i]);
            checks++;
            if (memWrite !== 1'b1) begin
                errors++;
                $display("FAIL basic_strobe%0d got=%b required=1", i, memWrite);
            end
        end
        inValid = 1'b0;
        checks++;
        if (done !== 1'b1 || cpuReset !== 1'b0 || bootPc !== 32'h20) begin
            errors++;
            $display("FAIL basic_release got done=%b cpurst=%b pc=%h required 1 0 00000020", done, cpuReset, bootPc);
        end
        idle(1);
        checks++;
        if ({rd(32'h20), rd(32'h21)} !== 32'h00000042) begin
            errors++;
            $display("FAIL basic_fetch got=%h required=00000042", {rd(32'h20), rd(32'h21)});
        end
        check_queue_empty("basic");
    endtask

    task automatic test_zero_count();
        int s;
        do_reset();
        s = n_strobes;
        send_word(16'h0000);
        send_word(16'h0010);
        send_word(16'h0000);
        send_word(16'h0000);
        inValid = 1'b0;
        checks++;
        if (done !== 1'b1 || cpuReset !== 1'b0 || bootPc !== 32'h10 || inReady !== 1'b0) begin
            errors++;
            $display("FAIL zero_release got done=%b cpurst=%b pc=%h rdy=%b required 1 0 00000010 0",
                     done, cpuReset, bootPc, inReady);
        end
        idle(3);
        checks++;
        if (n_strobes != s) begin
            errors++;
            $display("FAIL zero_strobes got=%0d required=0", n_strobes - s);
        end
    endtask

    task automatic test_toggle_valid();
        int s;
        do_reset();
        send_word(16'h0000);
        send_word(16'h0020);
        send_word(16'h0000);
        send_word(16'h0003);
        s = n_strobes;
        for (int i = 0; i < 3; i++) begin
            push_exp(32'h20 + 32'(i), 16'hA000 + 16'(i));
            send_word(16'hA000 + 16'(i));
            checks++;
            if (memWrite !== 1'b1) begin
                errors++;
                $display("FAIL toggle_strobe%0d got=%b required=1", i, memWrite);
            end
            if (i < 2) begin
                idle(1);
                checks++;
                if (memWrite !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL toggle_idle%0d got wr=%b done=%b required 0 0", i, memWrite, done);
                end
            end
        end
        idle(2);
        checks++;
        if (n_strobes - s != 3 || done !== 1'b1) begin
            errors++;
            $display("FAIL toggle_count got strobes=%0d done=%b required 3 1", n_strobes - s, done);
        end
        check_queue_empty("toggle");
    endtask

    task automatic test_out_of_range();
        do_reset();
        send_word(16'h000F);
        send_word(16'hFFFF);
        send_word(16'h0000);
        send_word(16'h0002);
        push_exp(32'h000FFFFF, 16'hAAAA);
        send_word(16'hAAAA);
        checks++;
        if (memWrite !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL range_first got wr=%b err=%b required 1 0", memWrite, err);
        end
        send_word(16'hBBBB);
        inValid = 1'b0;
        checks++;
        if (memWrite !== 1'b0 || err !== 1'b1 || done !== 1'b1 || bootPc !== 32'h000FFFFF) begin
            errors++;
            $display("FAIL range_second got wr=%b err=%b done=%b pc=%h required 0 1 1 000fffff",
                     memWrite, err, done, bootPc);
        end
        idle(2);
        check_queue_empty("range");
    endtask

    task automatic test_mid_reset();
        int s;
        do_reset();
        send_word(16'h0000);
        send_word(16'h0040);
        send_word(16'h0000);
        send_word(16'h0004);
        push_exp(32'h40, 16'h1111);
        send_word(16'h1111);
        push_exp(32'h41, 16'h2222);
        send_word(16'h2222);
        do_reset();
        s = n_strobes;
        checks++;
        if (cpuReset !== 1'b1 || done !== 1'b0 || memWrite !== 1'b0 || inReady !== 1'b1 || bootPc !== 32'h0) begin
            errors++;
            $display("FAIL midrst_state got cpurst=%b done=%b wr=%b rdy=%b pc=%h required 1 0 0 1 0",
                     cpuReset, done, memWrite, inReady, bootPc);
        end
        idle(3);
        checks++;
        if (n_strobes != s) begin
            errors++;
            $display("FAIL midrst_strobes got=%0d required=0", n_strobes - s);
        end
        send_word(16'h0000);
        send_word(16'h0080);
        send_word(16'h0000);
        send_word(16'h0002);
        push_exp(32'h80, 16'h3333);
        send_word(16'h3333);
        push_exp(32'h81, 16'h4444);
        send_word(16'h4444);
        inValid = 1'b0;
        checks++;
        if (done !== 1'b1 || cpuReset !== 1'b0 || bootPc !== 32'h80) begin
            errors++;
            $display("FAIL midrst_reload got done=%b cpurst=%b pc=%h required 1 0 00000080", done, cpuReset, bootPc);
        end
        idle(1);
        check_queue_empty("midrst");
    endtask

    task automatic test_after_done();
        int          s;
        logic [31:0] bp;
        s  = n_strobes;
        bp = bootPc;
        inValid = 1'b1;
        inData  = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            checks++;
            if (inReady !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("FAIL after_done_ready%0d got rdy=%b done=%b required 0 1", i, inReady, done);
            end
        end
        inValid = 1'b0;
        checks++;
        if (n_strobes != s || bootPc !== 32'h80 || bootPc !== bp) begin
            errors++;
            $display("FAIL after_done_quiet got strobes=%0d pc=%h required 0 00000080", n_strobes - s, bootPc);
        end
    endtask

    initial begin
        reset   = 1'b1;
        inValid = 1'b0;
        inData  = 16'h0000;
        @(negedge clk); #1;
        test_reset();
        test_basic_load();
        test_zero_count();
        test_toggle_valid();
        test_out_of_range();
        test_mid_reset();
        test_after_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
